// File: rtl/tx_ring_pkg.sv
// tx_ring_pkg: shared types and helpers for the transmit ring.
//   ENTRY_W        - stored entry width {last, nbytes[2:0], data[47:0]}
//   NB_W           - width of the per-entry byte count
//   state_e        - read-side FSM states
//   nbytes_from_be - valid byte count of a last word from its byte enables
package tx_ring_pkg;

   localparam int unsigned ENTRY_W = 52;
   localparam int unsigned NB_W    = 3;

   typedef enum logic [1:0] {IDLE, FETCH, SEND} state_e;

   // Count is set by the highest enabled byte; holes below it are still sent.
   // An all-zero mask is treated as a full word.
   function automatic logic [NB_W-1:0] nbytes_from_be(input logic [5:0] be);
      logic [NB_W-1:0] n;
      n = NB_W'(6);
      for (int i = 0; i < 6; i++) begin
         if (be[i]) n = NB_W'(i + 1);
      end
      return n;
   endfunction

endpackage

// File: rtl/tx_ring_mem.sv
// tx_ring_mem: simple dual-port RAM, DEPTH x WIDTH, single clock.
//   clk     - clock
//   wr_data - write word, wr_addr - write address, wr_en - write strobe
//   rd_addr - read address, rd_data - word at rd_addr one cycle later
// Synchronous read with no output register; contents are not reset.
module tx_ring_mem
   import tx_ring_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned WIDTH  = ENTRY_W
) (
   input  logic              clk,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/tx_ring.sv
// tx_ring: 32-entry store-and-forward transmit ring. Words pushed with byte
// enables are held until their frame commits, then serialised as bytes.
//   clk, rst                  - clock, async active-high reset
//   wr_data/wr_be/wr_last     - pushed word, byte enables (last word), end of frame
//   wr_valid/wr_ready         - push handshake
//   wr_drop                   - discard the uncommitted frame in progress
//   tx_data/tx_valid/tx_last  - byte stream toward the MAC, tx_ready accepts
//   used_cnt                  - occupied entries, committed plus uncommitted
//   frame_cnt                 - committed frames not yet fully sent
//   err_oversize, err_be      - one-cycle error pulses
module tx_ring
   import tx_ring_pkg::*;
#(
   parameter int unsigned DATA_W = 48,
   parameter int unsigned BE_W   = 6,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BE_W-1:0]   wr_be,
   input  logic              wr_last,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              wr_drop,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic              tx_last,
   input  logic              tx_ready,
   output logic [ADDR_W:0]   used_cnt,
   output logic [ADDR_W:0]   frame_cnt,
   output logic              err_oversize,
   output logic              err_be
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned PW    = ADDR_W + 1;

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      frame_cnt_q, frame_cnt_d;
   logic               discard_q, discard_d;
   logic               ovs_q, ovs_d, be_err_q, be_err_d;
   state_e             state_q, state_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic [NB_W-1:0]    nb_q, nb_d, idx_q, idx_d;
   logic               ent_last_q, ent_last_d;

   logic               full, accept, mem_we, commit, done;
   logic [NB_W-1:0]    wr_nb;
   logic [ENTRY_W-1:0] rd_data;

   assign used_cnt     = wr_ptr_q - rd_ptr_q;
   assign full         = (used_cnt == {1'b1, {ADDR_W{1'b0}}});
   // While discarding, words are swallowed even when the ring is full.
   assign wr_ready     = ~full | discard_q;
   assign accept       = wr_valid & wr_ready;
   assign frame_cnt    = frame_cnt_q;
   assign err_oversize = ovs_q;
   assign err_be       = be_err_q;
   assign wr_nb        = wr_last ? nbytes_from_be(wr_be) : NB_W'(6);

   // Write side: speculative pointer, commit, drop and oversize handling.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      cm_ptr_d  = cm_ptr_q;
      discard_d = discard_q;
      ovs_d     = 1'b0;
      be_err_d  = 1'b0;
      mem_we    = 1'b0;
      commit    = 1'b0;
      if (discard_q && accept && wr_last) discard_d = 1'b0;
      if (wr_drop) begin
         wr_ptr_d = cm_ptr_q;
      end else if (discard_q) begin
         // swallow words until the frame's last word
      end else if (full && frame_cnt_q == '0 && state_q == IDLE) begin
         // Ring holds only one unfinished frame: it can never fit.
         wr_ptr_d  = cm_ptr_q;
         discard_d = 1'b1;
         ovs_d     = 1'b1;
      end else if (accept) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (wr_last) begin
            cm_ptr_d = wr_ptr_q + PW'(1);
            commit   = 1'b1;
            be_err_d = (wr_be == '0);
         end
      end
   end

   // Read side: IDLE -> FETCH (RAM latency) -> SEND bytes of one entry.
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      shift_d    = shift_q;
      nb_d       = nb_q;
      idx_d      = idx_q;
      ent_last_d = ent_last_q;
      done       = 1'b0;
      tx_valid   = 1'b0;
      tx_last    = 1'b0;
      tx_data    = 8'h00;
      unique case (state_q)
         IDLE: begin
            if (frame_cnt_q != '0) state_d = FETCH;
         end
         FETCH: begin
            shift_d    = rd_data[DATA_W-1:0];
            nb_d       = rd_data[DATA_W+NB_W-1:DATA_W];
            ent_last_d = rd_data[ENTRY_W-1];
            idx_d      = '0;
            state_d    = SEND;
         end
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = shift_q[7:0];
            tx_last  = ent_last_q && (idx_q == nb_q - NB_W'(1));
            if (tx_ready) begin
               if (idx_q == nb_q - NB_W'(1)) begin
                  rd_ptr_d = rd_ptr_q + PW'(1);
                  if (ent_last_q) begin
                     done    = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = FETCH;
                  end
               end else begin
                  shift_d = shift_q >> 8;
                  idx_d   = idx_q + NB_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (commit && !done) frame_cnt_d = frame_cnt_q + PW'(1);
      if (!commit && done) frame_cnt_d = frame_cnt_q - PW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         cm_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         frame_cnt_q <= '0;
         discard_q   <= 1'b0;
         ovs_q       <= 1'b0;
         be_err_q    <= 1'b0;
         state_q     <= IDLE;
         shift_q     <= '0;
         nb_q        <= '0;
         idx_q       <= '0;
         ent_last_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         cm_ptr_q    <= cm_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         frame_cnt_q <= frame_cnt_d;
         discard_q   <= discard_d;
         ovs_q       <= ovs_d;
         be_err_q    <= be_err_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         nb_q        <= nb_d;
         idx_q       <= idx_d;
         ent_last_q  <= ent_last_d;
      end
   end

   // Address the next word one cycle ahead so FETCH sees it.
   tx_ring_mem #(
      .ADDR_W (ADDR_W),
      .WIDTH  (ENTRY_W)
   ) u_mem (
      .clk     (clk),
      .wr_data ({wr_last, wr_nb, wr_data}),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_en   (mem_we),
      .rd_addr (rd_ptr_d[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_tx_ring.sv
// tb_tx_ring: randomized and directed stimulus for tx_ring, checked every
// cycle against a frame/byte-queue model of the ring.
module tb_tx_ring;

   logic        clk, rst;
   logic [47:0] wr_data;
   logic [5:0]  wr_be;
   logic        wr_last, wr_valid, wr_ready, wr_drop;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_last, tx_ready;
   logic [5:0]  used_cnt, frame_cnt;
   logic        err_oversize, err_be;

   tx_ring u_dut (
      .clk          (clk),
      .rst          (rst),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .wr_last      (wr_last),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_drop      (wr_drop),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_last      (tx_last),
      .tx_ready     (tx_ready),
      .used_cnt     (used_cnt),
      .frame_cnt    (frame_cnt),
      .err_oversize (err_oversize),
      .err_be       (err_be)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: bytes as {frame_end, word_end, byte}.
   logic [9:0] exp_q[$];
   logic [9:0] cur_q[$];
   logic [8:0] rx_log[$];
   int  m_comm = 0, m_unc = 0, m_frames = 0;
   bit  m_discard = 0, exp_ovs = 0, exp_be = 0;
   bit  prev_stall = 0;
   logic [7:0] prev_data;
   logic       prev_last;
   int  hs_total = 0, ovs_seen = 0, be_seen = 0;
   int  rmode = 0;

   function automatic int model_nb(input logic [5:0] be);
      int n;
      n = 0;
      for (int i = 0; i < 6; i++) if (be[i]) n = i + 1;
      return (n == 0) ? 6 : n;
   endfunction

   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rmode == 0) tx_ready = 1'b0;
         else if (rmode == 1) tx_ready = 1'b1;
         else tx_ready = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin : mon
      int    used, fr_pre, n;
      bit    full_pre, rdy, acc, n_ovs, n_be;
      logic [9:0] h;
      if (rst) begin
         check("rst_tx_valid", tx_valid, 0);
         check("rst_wr_ready", wr_ready, 1);
         check("rst_used_cnt", used_cnt, 0);
         check("rst_frame_cnt", frame_cnt, 0);
         exp_q.delete();
         cur_q.delete();
         m_comm = 0; m_unc = 0; m_frames = 0;
         m_discard = 0; exp_ovs = 0; exp_be = 0; prev_stall = 0;
      end else begin
         used     = m_comm + m_unc;
         full_pre = (used == 32);
         fr_pre   = m_frames;
         rdy      = !full_pre || m_discard;
         check("wr_ready", wr_ready, int'(rdy));
         check("used_cnt", used_cnt, used);
         check("frame_cnt", frame_cnt, m_frames);
         check("err_oversize", err_oversize, int'(exp_ovs));
         check("err_be", err_be, int'(exp_be));
         ovs_seen += int'(err_oversize);
         be_seen  += int'(err_be);
         if (exp_q.size() == 0) check("tx_spurious", tx_valid, 0);
         if (prev_stall) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
            check("hold_last", tx_last, prev_last);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_last  = tx_last;
         if (tx_valid && tx_ready) begin
            rx_log.push_back({tx_last, tx_data});
            hs_total++;
            if (exp_q.size() > 0) begin
               h = exp_q.pop_front();
               check("tx_data", tx_data, h[7:0]);
               check("tx_last", tx_last, h[9]);
               if (h[8]) m_comm--;
               if (h[9]) m_frames--;
            end
         end
         acc   = wr_valid && rdy;
         n_ovs = 0;
         n_be  = 0;
         if (wr_drop) begin
            cur_q.delete();
            m_unc = 0;
            if (acc && wr_last) m_discard = 0;
         end else if (m_discard) begin
            if (acc && wr_last) m_discard = 0;
         end else if (full_pre && fr_pre == 0) begin
            cur_q.delete();
            m_unc     = 0;
            m_discard = 1;
            n_ovs     = 1;
         end else if (acc) begin
            n = wr_last ? model_nb(wr_be) : 6;
            for (int i = 0; i < n; i++)
               cur_q.push_back({wr_last && (i == n - 1), i == n - 1, wr_data[8*i +: 8]});
            m_unc++;
            if (wr_last) begin
               while (cur_q.size() > 0) exp_q.push_back(cur_q.pop_front());
               m_comm  += m_unc;
               m_unc    = 0;
               m_frames++;
               n_be     = (wr_be == 6'h00);
            end
         end
         exp_ovs = n_ovs;
         exp_be  = n_be;
      end
   end

   // All drivers change inputs 1 time unit after a rising edge.
   task automatic push(input logic [47:0] d, input logic [5:0] be, input bit last,
                       input bit drop);
      bit ok;
      ok       = 0;
      wr_data  = d;
      wr_be    = be;
      wr_last  = last;
      wr_drop  = drop;
      wr_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         ok = wr_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      wr_valid = 1'b0;
      wr_drop  = 1'b0;
      wr_last  = 1'b0;
      check("push_accepted", int'(ok), 1);
   endtask

   task automatic drain(input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !tx_valid) begin
            ok = 1;
            break;
         end
      end
      check("drain_done", int'(ok), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] rnd48();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[47:0];
   endfunction

   initial begin
      int base_hs, base_ovs, base_be, nw, drop_at;
      bit ok;
      rst = 1'b1;
      wr_data = '0; wr_be = '0; wr_last = 0; wr_valid = 0; wr_drop = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);

      // Two-word frame, last word carries two bytes.
      rx_log.delete();
      push(48'h060504030201, 6'h3f, 0, 0);
      push(48'hAABBCCDD0807, 6'b000011, 1, 0);
      idle(1);
      check("t1_frame_cnt_one", frame_cnt, 1);
      rmode = 1;
      drain(200);
      check("t1_frame_cnt_zero", frame_cnt, 0);
      check("t1_len", rx_log.size(), 8);
      for (int i = 0; i < 8 && i < rx_log.size(); i++) begin
         check("t1_byte", rx_log[i][7:0], i + 1);
         check("t1_last", rx_log[i][8], int'(i == 7));
      end

      // Drop mid-frame, then a short frame.
      rx_log.delete();
      base_hs = hs_total;
      push(48'h111111111111, 6'h3f, 0, 0);
      push(48'h222222222222, 6'h3f, 0, 1);
      idle(4);
      check("t2_no_tx", hs_total - base_hs, 0);
      check("t2_used_zero", used_cnt, 0);
      push(48'h000000332211, 6'b000100, 1, 0);
      drain(200);
      check("t2_len", rx_log.size(), 3);
      if (rx_log.size() == 3) begin
         check("t2_b0", rx_log[0], 9'h011);
         check("t2_b2", rx_log[2], 9'h133);
      end

      // Zero byte-enable on last word.
      rx_log.delete();
      base_be = be_seen;
      push(48'h665544332211, 6'h00, 1, 0);
      drain(200);
      check("be0_pulse", be_seen - base_be, 1);
      check("be0_len", rx_log.size(), 6);
      if (rx_log.size() == 6) check("be0_last", rx_log[5], 9'h166);

      // 33-word frame into an empty ring.
      base_hs  = hs_total;
      base_ovs = ovs_seen;
      for (int w = 0; w < 33; w++) push(rnd48(), 6'h3f, w == 32, 0);
      idle(4);
      check("ovs_pulses", ovs_seen - base_ovs, 1);
      check("ovs_no_tx", hs_total - base_hs, 0);
      check("ovs_used_zero", used_cnt, 0);

      // Four committed 8-word frames fill the ring.
      rmode   = 0;
      idle(1);
      base_hs = hs_total;
      for (int f = 0; f < 4; f++)
         for (int w = 0; w < 8; w++) push(rnd48(), 6'h3f, w == 7, 0);
      idle(3);
      check("fill_used", used_cnt, 32);
      check("fill_ready", wr_ready, 0);
      check("fill_frames", frame_cnt, 4);
      rmode = 1;
      ok    = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (used_cnt != 6'd32) begin
            ok = 1;
            break;
         end
      end
      check("fill_popped", int'(ok), 1);
      check("fill_used_31", used_cnt, 31);
      check("fill_ready_again", wr_ready, 1);
      @(posedge clk);
      #1;
      drain(2000);
      check("fill_bytes", hs_total - base_hs, 192);

      // Random frames with random backpressure and occasional drops.
      rmode = 2;
      for (int f = 0; f < 25; f++) begin
         nw      = $urandom_range(1, 5);
         drop_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nw - 1) : 99;
         for (int w = 0; w < nw; w++) begin
            push(rnd48(), ($urandom_range(0, 7) == 0) ? 6'h00 : 6'($urandom_range(1, 63)),
                 w == nw - 1, w == drop_at);
            if (w == drop_at) break;
         end
         idle($urandom_range(0, 2));
      end
      drain(3000);

      // Reset in the middle of a word.
      rmode   = 1;
      push(48'h0C0B0A090807, 6'h3f, 0, 0);
      push(48'h121110_0F0E0D, 6'h3f, 1, 0);
      base_hs = hs_total;
      ok      = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (hs_total - base_hs >= 3) begin
            ok = 1;
            break;
         end
      end
      check("rst_reached_byte3", int'(ok), 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_tx_valid", tx_valid, 0);
      check("arst_tx_data", tx_data, 0);
      check("arst_tx_last", tx_last, 0);
      check("arst_wr_ready", wr_ready, 1);
      check("arst_used", used_cnt, 0);
      check("arst_frames", frame_cnt, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      rx_log.delete();
      push(48'hF6F5F4F3F2F1, 6'h3f, 1, 0);
      drain(200);
      check("post_rst_len", rx_log.size(), 6);
      if (rx_log.size() == 6) begin
         check("post_rst_b0", rx_log[0], 9'h0F1);
         check("post_rst_b5", rx_log[5], 9'h1F6);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
